// File: rtl/enc_period_ctrl.sv
// Encoder period measurement controller: times the gap between filtered encoder edges.
// Optional macro ENC_PERIOD_AVG_EN publishes a 4-capture moving average instead of raw captures.
module enc_period_ctrl #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enc_pos,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] timeout_lim,
   input  logic          period_ack,
   output logic [CW-1:0] period,
   output logic          period_valid,
   output logic          overrun,
   output logic          stalled,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      COUNT = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] counter_r;
   logic          capture_s;
   logic          timeout_s;
   logic          arm_s;
   logic          busy_s;
   logic          publish_s;
   logic [CW-1:0] publish_val_s;

   // Qualified events; stop masks everything else in the same cycle.
   always_comb begin
      capture_s = (state_r == COUNT) && enc_pos && !stop;
      timeout_s = (state_r == COUNT) && !enc_pos && !stop &&
                  (timeout_lim != CNT_ZERO) && (counter_r == timeout_lim);
      arm_s     = (state_r == IDLE) && start && !stop;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      if (stop) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (start)     state_s = SYNC;  else state_s = IDLE;
            SYNC:    if (enc_pos)   state_s = COUNT; else state_s = SYNC;
            COUNT:   if (timeout_s) state_s = SYNC;  else state_s = COUNT;
            default: state_s = IDLE;
         endcase
      end
   end

   // FSM outputs, registered below together with the status flags.
   always_comb begin
      busy_s = (state_s != IDLE);
   end

   // Period counter: restarts at 1 after each edge so edge-to-edge gap equals count.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter_r <= CNT_ZERO;
      end else if (stop) begin
         counter_r <= CNT_ZERO;
      end else begin
         case (state_r)
            SYNC: begin
               if (enc_pos) counter_r <= CNT_ONE;
               else         counter_r <= CNT_ZERO;
            end
            COUNT: begin
               if (capture_s)                counter_r <= CNT_ONE;
               else if (timeout_s)           counter_r <= CNT_ZERO;
               else if (counter_r != CNT_MAX) counter_r <= counter_r + CNT_ONE;
               else                          counter_r <= counter_r;
            end
            default: counter_r <= CNT_ZERO;
         endcase
      end
   end

`ifdef ENC_PERIOD_AVG_EN
   logic [CW-1:0] hist0_r;
   logic [CW-1:0] hist1_r;
   logic [CW-1:0] hist2_r;
   logic [1:0]    hist_cnt_r;
   logic [CW+1:0] sum_s;

   // Publish only once three earlier captures plus the current one are available.
   always_comb begin
      sum_s = {2'b00, counter_r} + {2'b00, hist0_r} + {2'b00, hist1_r} + {2'b00, hist2_r};
      publish_s     = capture_s && (hist_cnt_r == 2'd3);
      publish_val_s = sum_s[CW+1:2];
   end

   // Capture history; any exit from COUNT discards it.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist0_r    <= CNT_ZERO;
         hist1_r    <= CNT_ZERO;
         hist2_r    <= CNT_ZERO;
         hist_cnt_r <= 2'd0;
      end else if (state_r != COUNT) begin
         hist0_r    <= CNT_ZERO;
         hist1_r    <= CNT_ZERO;
         hist2_r    <= CNT_ZERO;
         hist_cnt_r <= 2'd0;
      end else if (capture_s) begin
         hist2_r <= hist1_r;
         hist1_r <= hist0_r;
         hist0_r <= counter_r;
         if (hist_cnt_r != 2'd3) hist_cnt_r <= hist_cnt_r + 2'd1;
         else                    hist_cnt_r <= hist_cnt_r;
      end else begin
         hist_cnt_r <= hist_cnt_r;
      end
   end
`else
   // Raw mode: every capture is published directly.
   always_comb begin
      publish_s     = capture_s;
      publish_val_s = counter_r;
   end
`endif

   // Output register and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         period       <= CNT_ZERO;
         period_valid <= 1'b0;
         overrun      <= 1'b0;
         stalled      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         busy <= busy_s;
         if (publish_s) begin
            period       <= publish_val_s;
            period_valid <= 1'b1;
            if (period_valid && !period_ack) overrun <= 1'b1;
            else                             overrun <= overrun;
         end else begin
            if (period_ack) period_valid <= 1'b0;
            else            period_valid <= period_valid;
            if (arm_s) overrun <= 1'b0;
            else       overrun <= overrun;
         end
         if (stop || capture_s) stalled <= 1'b0;
         else if (timeout_s)    stalled <= 1'b1;
         else                   stalled <= stalled;
      end
   end

endmodule
